// File: rtl/md_sched.sv
// Multiply/divide sequencer beside the EX-stage ALU. It owns HI/LO and models the fixed
// mult/div latency with a down-counter, raising a stall request while the unit is occupied.
//
// state | meaning
// IDLE  | unit free; mult/div accepted, mthi/mtlo written directly
// RUN   | result pending in pend_hi/pend_lo; commits when counter reaches 0
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        md_use_id,
  output logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_nowr;

  logic [63:0]      prod_s, prod_u;
  logic [31:0]      div_bs, div_bu, q_s, r_s, q_u, r_u;
  logic             div_zero, div_ovf;
  logic [31:0]      res_hi, res_lo;
  logic             res_nowr;
  logic [CNT_W-1:0] res_ld;

  assign start     = (md_op >= OP_MULT) && (md_op <= OP_DIVU) && (state == IDLE);
  assign stall_req = md_use_id & (start | busy);

  // Divisors are forced to 1 in the zero and MIN/-1 cases so the dividers never trap;
  // those cases are resolved explicitly below.
  always_comb begin
    prod_s   = {{32{operand_a[31]}}, operand_a} * {{32{operand_b[31]}}, operand_b};
    prod_u   = {32'b0, operand_a} * {32'b0, operand_b};
    div_zero = (operand_b == 32'd0);
    div_ovf  = (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
    div_bs   = (div_zero || div_ovf) ? 32'd1 : operand_b;
    div_bu   = div_zero ? 32'd1 : operand_b;
    q_s      = $signed(operand_a) / $signed(div_bs);
    r_s      = $signed(operand_a) % $signed(div_bs);
    q_u      = operand_a / div_bu;
    r_u      = operand_a % div_bu;

    res_hi   = prod_s[63:32];
    res_lo   = prod_s[31:0];
    res_nowr = 1'b0;
    res_ld   = MULT_LD;
    case (md_op)
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        res_hi   = div_ovf ? 32'd0 : r_s;
        res_lo   = div_ovf ? 32'h8000_0000 : q_s;
        res_nowr = div_zero;
        res_ld   = DIV_LD;
      end
      OP_DIVU: begin
        res_hi   = r_u;
        res_lo   = q_u;
        res_nowr = div_zero;
        res_ld   = DIV_LD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_nowr <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pend_hi   <= res_hi;
            pend_lo   <= res_lo;
            pend_nowr <= res_nowr;
            cnt       <= res_ld;
            state     <= RUN;
            busy      <= 1'b1;
          end else if (md_op == OP_MTHI) begin
            hi <= operand_a;
          end else if (md_op == OP_MTLO) begin
            lo <= operand_a;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!pend_nowr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: expected HI/LO pushed to a scoreboard when an op is
// issued, popped and compared when busy falls.
module tb_md_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] operand_a, operand_b;
  logic        md_use_id;
  logic        start, busy, stall_req;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] l;
  } res_t;
  res_t sb[$];

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .operand_a(operand_a),
    .operand_b(operand_b), .md_use_id(md_use_id), .start(start), .busy(busy),
    .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a mult/div op, count busy cycles (bounded), then compare against the scoreboard.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc, input logic [31:0] eh,
                        input logic [31:0] el, input logic inject);
    res_t r;
    int n;
    md_op = op; operand_a = a; operand_b = b;
    #1;
    check({tag, " start"}, {31'b0, start}, 32'd1);
    check({tag, " stall_accept"}, {31'b0, stall_req}, {31'b0, md_use_id});
    r.h = eh; r.l = el;
    sb.push_back(r);
    @(posedge clk); #1;
    md_op = 3'd0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      check({tag, " stall_busy"}, {31'b0, stall_req}, {31'b0, md_use_id});
      if (inject && n == 2) begin
        md_op = 3'd1; operand_a = 32'd7; operand_b = 32'd7;
      end else begin
        md_op = 3'd0;
      end
      @(posedge clk); #1;
    end
    md_op = 3'd0;
    check({tag, " busy_cycles"}, n, ncyc);
    check({tag, " stall_after"}, {31'b0, stall_req}, 32'd0);
    r = sb.pop_front();
    check({tag, " hi"}, hi, r.h);
    check({tag, " lo"}, lo, r.l);
  endtask

  initial begin
    reset = 1'b0; md_op = 3'd1; md_use_id = 1'b1; operand_a = '0; operand_b = '0;
    #2;
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst start_eq", {31'b0, start}, 32'd1);
    md_op = 3'd0;
    #1;
    check("rst stall_idle", {31'b0, stall_req}, 32'd0);
    md_use_id = 1'b0;
    #9 reset = 1'b1;
    @(posedge clk); #1;

    run_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0);

    md_op = 3'd5; operand_a = 32'h1234;
    #1 check("mthi start", {31'b0, start}, 32'd0);
    @(posedge clk); #1;
    md_op = 3'd0;
    check("mthi hi", hi, 32'h1234);
    check("mthi lo_keep", lo, 32'h8000_0000);
    check("mthi busy", {31'b0, busy}, 32'd0);

    md_op = 3'd6; operand_a = 32'h5678;
    @(posedge clk); #1;
    md_op = 3'd0;
    check("mtlo lo", lo, 32'h5678);
    check("mtlo hi_keep", hi, 32'h1234);
    check("mtlo busy", {31'b0, busy}, 32'd0);

    run_op("divu0", 3'd4, 32'd100, 32'd0, 10, 32'h1234, 32'h5678, 1'b0);
    run_op("divu",  3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);

    md_use_id = 1'b1;
    run_op("hazard", 3'd1, 32'd2, 32'd3, 5, 32'd0, 32'd6, 1'b1);
    md_use_id = 1'b0;

    // Reset in busy cycle 3 of a div must abandon it.
    md_op = 3'd3; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2;
    @(posedge clk); #1;
    md_op = 3'd0;
    repeat (2) @(posedge clk);
    #3;
    check("rstrun busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("rstrun busy", {31'b0, busy}, 32'd0);
    check("rstrun hi", hi, 32'd0);
    check("rstrun lo", lo, 32'd0);
    #10 reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("rstrun hi_after", hi, 32'd0);
    check("rstrun lo_after", lo, 32'd0);
    check("rstrun busy_after", {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
